// File: rtl/hs_pkg.sv
// Shared constants and helpers for the buffered valid/ready handshake source.
package hs_pkg;

    localparam int MODE_STROBE = 0;
    localparam int MODE_CHANGE = 1;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/handshake_master_fifo_if.sv
// Producer/consumer/status bundle of the buffered handshake source.
interface handshake_master_fifo_if
    import hs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) ();
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] data_in;
    logic              in_valid;
    logic              in_ready;
    logic              ready_inp;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              clr_ovf;

    modport master (
        input  data_in, in_valid, ready_inp, clr_ovf,
        output in_ready, data, valid, count, full, empty, overflow
    );

    modport slave (
        output data_in, in_valid, ready_inp, clr_ovf,
        input  in_ready, data, valid, count, full, empty, overflow
    );

endinterface

// File: rtl/hs_sync_fifo.sv
// Synchronous FIFO storage: naturally wrapping pointers, occupancy count, unreset memory.
module hs_sync_fifo
    import hs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int CW    = cnt_w(DEPTH),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count
);
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign push_ok_s = push && (count_r != CW'(DEPTH));
    assign pop_ok_s  = pop && (count_r != {CW{1'b0}});

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage is left unreset.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/handshake_master_fifo.sv
// Buffered valid/ready source: strobe or capture-on-change input, sticky overflow status.
module handshake_master_fifo
    import hs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int MODE   = MODE_STROBE,
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    handshake_master_fifo_if.master bus
);
    logic [DATA_W-1:0] last_r;
    logic              ovf_r;
    logic [DATA_W-1:0] rdata_s;
    logic [CW-1:0]     count_s;
    logic              full_s;
    logic              empty_s;
    logic              change_s;
    logic              push_s;
    logic              drop_s;
    logic              pop_s;

    assign full_s  = (count_s == CW'(DEPTH));
    assign empty_s = (count_s == {CW{1'b0}});
    assign pop_s   = !empty_s && bus.ready_inp;

    // Capture decision uses registered fullness only, so a same-cycle pop never frees a slot.
    always_comb begin
        change_s = 1'b0;
        push_s   = 1'b0;
        drop_s   = 1'b0;
        if (MODE == MODE_CHANGE) begin
            change_s = (bus.data_in != last_r);
            push_s   = change_s && !full_s;
            drop_s   = change_s && full_s;
        end else begin
            push_s   = bus.in_valid && !full_s;
        end
    end

    // Last-captured value and sticky overflow; a new drop beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= {DATA_W{1'b0}};
            ovf_r  <= 1'b0;
        end else begin
            if (change_s) last_r <= bus.data_in;
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_r <= 1'b0;
            end
        end
    end

    hs_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (bus.data_in),
        .rdata (rdata_s),
        .count (count_s)
    );

    assign bus.data     = empty_s ? {DATA_W{1'b0}} : rdata_s;
    assign bus.valid    = !empty_s;
    assign bus.in_ready = !full_s;
    assign bus.count    = count_s;
    assign bus.full     = full_s;
    assign bus.empty    = empty_s;
    assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_handshake_master_fifo.sv
// Directed + random bench: strobe-mode and change-mode instances checked against queue models.
module tb_handshake_master_fifo;
    import hs_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    handshake_master_fifo_if #(.DATA_W(8), .DEPTH(4)) ifa ();
    handshake_master_fifo_if #(.DATA_W(8), .DEPTH(4)) ifb ();

    handshake_master_fifo #(.DATA_W(8), .DEPTH(4), .MODE(MODE_STROBE)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa));
    handshake_master_fifo #(.DATA_W(8), .DEPTH(4), .MODE(MODE_CHANGE)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb));

    int vectors = 0;
    int fails   = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] lastb = 8'h00;
    logic       ovfb  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_data",  ifa.data,     (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
        chk("a_valid", ifa.valid,    32'(qa.size() != 0));
        chk("a_count", ifa.count,    32'(qa.size()));
        chk("a_full",  ifa.full,     32'(qa.size() == 4));
        chk("a_empty", ifa.empty,    32'(qa.size() == 0));
        chk("a_inrdy", ifa.in_ready, 32'(qa.size() < 4));
        chk("a_ovf",   ifa.overflow, 32'd0);
        chk("b_data",  ifb.data,     (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
        chk("b_valid", ifb.valid,    32'(qb.size() != 0));
        chk("b_count", ifb.count,    32'(qb.size()));
        chk("b_full",  ifb.full,     32'(qb.size() == 4));
        chk("b_empty", ifb.empty,    32'(qb.size() == 0));
        chk("b_ovf",   ifb.overflow, 32'(ovfb));
    endtask

    // One clock: model the transfer from pre-edge inputs, then compare after the edge.
    task automatic step();
        bit         pa, wa, pb, chg, fullb, clr;
        logic [7:0] da, db;
        pa    = (qa.size() != 0) && ifa.ready_inp;
        wa    = ifa.in_valid && (qa.size() < 4);
        da    = ifa.data_in;
        pb    = (qb.size() != 0) && ifb.ready_inp;
        db    = ifb.data_in;
        chg   = (db != lastb);
        fullb = (qb.size() == 4);
        clr   = ifb.clr_ovf;
        @(posedge clk);
        if (pa) void'(qa.pop_front());
        if (wa) qa.push_back(da);
        if (pb) void'(qb.pop_front());
        if (chg) begin
            if (fullb) ovfb = 1'b1;
            else       qb.push_back(db);
            lastb = db;
        end
        if (clr && !(chg && fullb)) ovfb = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] seq [5];
        seq = '{8'h05, 8'h05, 8'h07, 8'h07, 8'h05};
        rst = 1'b1;
        ifa.data_in = 8'h00; ifa.in_valid = 1'b0; ifa.ready_inp = 1'b0; ifa.clr_ovf = 1'b0;
        ifb.data_in = 8'h00; ifb.in_valid = 1'b0; ifb.ready_inp = 1'b0; ifb.clr_ovf = 1'b0;
        #1;
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;

        // Strobe mode: fill with stalled consumer, then drain.
        for (int i = 0; i < 4; i++) begin
            ifa.in_valid = 1'b1;
            ifa.data_in  = 8'(8'h11 * (i + 1));
            step();
        end
        chk("a_fill_full", ifa.full, 32'd1);
        chk("a_fill_head", ifa.data, 32'h11);
        chk("a_fill_inrdy", ifa.in_ready, 32'd0);
        ifa.data_in = 8'h55;
        step();
        ifa.in_valid = 1'b0;
        step();
        chk("a_hold_head", ifa.data, 32'h11);
        ifa.ready_inp = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("a_drained", ifa.empty, 32'd1);

        // Strobe mode: push every cycle with consumer always ready.
        for (int i = 1; i <= 8; i++) begin
            ifa.in_valid = 1'b1;
            ifa.data_in  = 8'(i);
            step();
            chk("a_stream_cnt", ifa.count, 32'd1);
            chk("a_stream_dat", ifa.data, 32'(i));
        end
        ifa.in_valid = 1'b0;
        step();

        // Change mode: duplicates collapse.
        for (int i = 0; i < 5; i++) begin
            ifb.data_in = seq[i];
            step();
        end
        chk("b_chg_cnt", ifb.count, 32'd3);
        ifb.data_in = 8'h09;
        step();
        chk("b_chg_full", ifb.full, 32'd1);
        ifb.ready_inp = 1'b1;
        ifb.data_in   = 8'h99;
        step();
        chk("b_drop_ovf", ifb.overflow, 32'd1);
        chk("b_drop_cnt", ifb.count, 32'd3);
        ifb.ready_inp = 1'b0;
        ifb.clr_ovf   = 1'b1;
        step();
        ifb.clr_ovf   = 1'b0;
        chk("b_clr_ovf", ifb.overflow, 32'd0);
        ifb.data_in = 8'h44;
        step();
        ifb.clr_ovf = 1'b1;
        ifb.data_in = 8'h45;
        step();
        chk("b_clr_vs_drop", ifb.overflow, 32'd1);
        step();
        ifb.clr_ovf = 1'b0;
        chk("b_clr2", ifb.overflow, 32'd0);
        ifb.ready_inp = 1'b1;
        for (int i = 0; i < 5; i++) step();
        ifb.ready_inp = 1'b0;
        ifa.ready_inp = 1'b0;

        // Asynchronous reset with words in flight.
        for (int i = 0; i < 3; i++) begin
            ifa.in_valid = 1'b1;
            ifa.data_in  = 8'(8'hA0 + i);
            ifb.data_in  = 8'(8'hB0 + i);
            step();
        end
        ifa.in_valid = 1'b0;
        chk("a_pre_rst_cnt", ifa.count, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        qa.delete(); qb.delete(); ovfb = 1'b0; lastb = 8'h00;
        chk("rst_a_valid", ifa.valid, 32'd0);
        chk("rst_a_data",  ifa.data,  32'd0);
        chk("rst_a_count", ifa.count, 32'd0);
        chk("rst_b_count", ifb.count, 32'd0);
        chk("rst_b_ovf",   ifb.overflow, 32'd0);
        ifb.data_in = 8'h00;
        @(posedge clk); #1;
        check_all();
        rst = 1'b0;

        // Random traffic with consumer stalls.
        for (int i = 0; i < 400; i++) begin
            ifa.in_valid  = 1'($urandom_range(0, 1));
            ifa.data_in   = 8'($urandom);
            ifa.ready_inp = ($urandom_range(0, 2) == 0);
            ifb.data_in   = 8'($urandom_range(0, 3));
            ifb.ready_inp = ($urandom_range(0, 2) == 0);
            ifb.clr_ovf   = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
